// File: rtl/cls_beat_argmax8.sv
// cls_beat_argmax8: per-beat masked class-score argmax over eight byte lanes
// through a registered 8->4->2->1 compare tree, tagged with beat/anchor numbers.
module cls_beat_argmax8 #(
  parameter int NUM_CLASS  = 80,
  parameter int NUM_ANCHOR = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        yolo_layer_finish,
  input  logic        din_valid,
  input  logic [63:0] din,
  output logic        en,
  output logic [3:0]  trans_cnt,
  output logic [1:0]  anchor_sel_t,
  output logic [7:0]  cmax8_value_x,
  output logic [2:0]  cmax8_index_x
);
  localparam int BEATS = (NUM_CLASS + 5 + 7) / 8;
  localparam int L = NUM_CLASS + 5 - 8 * (BEATS - 1);
  localparam logic [3:0] LAST_BEAT = 4'(BEATS);
  localparam logic [1:0] LAST_ANCHOR = 2'(NUM_ANCHOR);
  localparam logic [7:0] LAST_MASK = 8'((1 << L) - 1);
  // candidate = {valid, value, lane}; valid beats invalid, then larger value, then lower lane
  function automatic logic [11:0] pick(input logic [11:0] a, input logic [11:0] b);
    return (a[11] && (!b[11] || a[10:3] > b[10:3] ||
           (a[10:3] == b[10:3] && a[2:0] < b[2:0]))) ? a : b;
  endfunction
  logic [3:0] beat;
  logic [1:0] anchor;
  logic [7:0] mask;
  logic [7:0][11:0] c0;
  logic [3:0][11:0] n1, c1;
  logic [1:0][11:0] n2, c2;
  logic [11:0] n3;
  logic v1, v2;
  logic [3:0] t1, t2;
  logic [1:0] a1, a2;
  always_comb begin
    mask = beat == 4'd1 ? 8'hE0 : beat == LAST_BEAT ? LAST_MASK : 8'hFF;
    for (int i = 0; i < 8; i++) c0[i] = {mask[i], din[8*i +: 8], 3'(i)};
    for (int i = 0; i < 4; i++) n1[i] = pick(c0[2*i], c0[2*i+1]);
    for (int i = 0; i < 2; i++) n2[i] = pick(c1[2*i], c1[2*i+1]);
    n3 = pick(c2[0], c2[1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= 4'd1;
      anchor <= 2'd1;
      c1 <= '0;
      c2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      t1 <= '0;
      t2 <= '0;
      a1 <= '0;
      a2 <= '0;
      en <= 1'b0;
      trans_cnt <= '0;
      anchor_sel_t <= '0;
      cmax8_value_x <= '0;
      cmax8_index_x <= '0;
    end else if (yolo_layer_finish) begin
      beat <= 4'd1;
      anchor <= 2'd1;
      v1 <= 1'b0;
      v2 <= 1'b0;
      en <= 1'b0;
    end else begin
      if (din_valid) begin
        beat <= beat == LAST_BEAT ? 4'd1 : beat + 4'd1;
        if (beat == LAST_BEAT) anchor <= anchor == LAST_ANCHOR ? 2'd1 : anchor + 2'd1;
      end
      c1 <= n1;
      t1 <= beat;
      a1 <= anchor;
      v1 <= din_valid;
      c2 <= n2;
      t2 <= t1;
      a2 <= a1;
      v2 <= v1;
      en <= v2;
      if (v2) begin
        trans_cnt <= t2;
        anchor_sel_t <= a2;
        cmax8_value_x <= n3[10:3];
        cmax8_index_x <= n3[2:0];
      end
    end
  end
endmodule

// File: tb/tb_cls_beat_argmax8.sv
// tb_cls_beat_argmax8: scoreboard bench; expected beats queued at drive time, checked on en.
module tb_cls_beat_argmax8;
  localparam int NC = 80;
  localparam int NA = 3;
  localparam int NB = (NC + 12) / 8;
  logic clk = 1'b0, rst = 1'b1, yolo_layer_finish = 1'b0, din_valid = 1'b0;
  logic [63:0] din = '0;
  logic en;
  logic [3:0] trans_cnt;
  logic [1:0] anchor_sel_t;
  logic [7:0] cmax8_value_x;
  logic [2:0] cmax8_index_x;
  typedef struct {
    logic [3:0] tc;
    logic [1:0] an;
    logic [7:0] v;
    logic [2:0] i;
    int due;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, mt = 1, ma = 1;
  cls_beat_argmax8 #(.NUM_CLASS(NC), .NUM_ANCHOR(NA)) dut (
    .clk(clk), .rst(rst), .yolo_layer_finish(yolo_layer_finish),
    .din_valid(din_valid), .din(din), .en(en), .trans_cnt(trans_cnt),
    .anchor_sel_t(anchor_sel_t), .cmax8_value_x(cmax8_value_x),
    .cmax8_index_x(cmax8_index_x)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && en) begin
      if (q.size() == 0) check("unexpected_en", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("trans_cnt", trans_cnt, e.tc);
        check("anchor_sel_t", anchor_sel_t, e.an);
        check("value", cmax8_value_x, e.v);
        check("index", cmax8_index_x, e.i);
        check("latency", cyc, e.due);
      end
    end
  end
  // drive one beat at a negedge; hand=1 uses the given expected value/index
  task automatic send(input logic [63:0] d, input bit hand, input logic [7:0] hv, input logic [2:0] hi);
    exp_t e;
    int p;
    bit found;
    found = 0;
    e.v = 0;
    e.i = 0;
    for (int i = 0; i < 8; i++) begin
      p = 8 * (mt - 1) + i;
      if (p >= 5 && p < NC + 5 && (!found || d[8*i +: 8] > e.v)) begin
        found = 1;
        e.v = d[8*i +: 8];
        e.i = 3'(i);
      end
    end
    if (hand) begin
      e.v = hv;
      e.i = hi;
    end
    e.tc = 4'(mt);
    e.an = 2'(ma);
    e.due = cyc + 3;
    q.push_back(e);
    din = d;
    din_valid = 1'b1;
    if (mt == NB) begin
      mt = 1;
      ma = ma == NA ? 1 : ma + 1;
    end else mt++;
    @(negedge clk);
    din_valid = 1'b0;
  endtask
  function automatic logic [63:0] rnd_beat();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = $urandom_range(0, 2) == 0 ? 8'hC0 : 8'($urandom);
    return d;
  endfunction
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_en", en, 0);
    check("rst_tc", trans_cnt, 0);
    check("rst_an", anchor_sel_t, 0);
    check("rst_val", cmax8_value_x, 0);
    check("rst_idx", cmax8_index_x, 0);
    send(64'h0706050403FFFFFF, 1, 8'h07, 3'd7);
    send(64'h4090404040904040, 1, 8'h90, 3'd2);
    for (int b = 3; b < NB; b++) send(rnd_beat(), 0, 0, 0);
    send(64'hFFFFFF1010101010, 1, 8'h10, 3'd0);
    send(rnd_beat(), 0, 0, 0);
    drain();
    send(rnd_beat(), 0, 0, 0);
    send(rnd_beat(), 0, 0, 0);
    yolo_layer_finish = 1'b1;
    din_valid = 1'b1;
    din = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    yolo_layer_finish = 1'b0;
    din_valid = 1'b0;
    q.delete();
    mt = 1;
    ma = 1;
    repeat (5) @(negedge clk);
    for (int b = 0; b < 3 * NB + 1; b++) send(rnd_beat(), 0, 0, 0);
    drain();
    for (int b = 0; b < 5; b++) begin
      send(rnd_beat(), 0, 0, 0);
      if (b == 2) repeat (2) @(negedge clk);
    end
    drain();
    send(64'h0102030405060708, 1, 8'h08, 3'd0);
    send(rnd_beat(), 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_en", en, 0);
    check("arst_tc", trans_cnt, 0);
    check("arst_an", anchor_sel_t, 0);
    check("arst_val", cmax8_value_x, 0);
    check("arst_idx", cmax8_index_x, 0);
    #1 rst = 1'b0;
    q.delete();
    mt = 1;
    ma = 1;
    @(negedge clk);
    send(64'hAA00000000000000, 1, 8'hAA, 3'd7);
    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
